// File: rtl/matrix_vector_multiplier_if.sv
// Start/done bus between the control logic and the matrix-vector multiplier.
// The controller drives the request side and the multiplier drives the result side.
//   start - request pulse, sampled while the multiplier is idle
//   mat   - matrix operand, mat[i][j] = row i, column j
//   vec   - vector operand, vec[j]
//   res   - result register, res[i] = dot(row i, vec)
//   busy  - computation in progress
//   done  - one-cycle pulse when res holds a new complete result
// Modports: master = controller side, slave = multiplier side.
interface matrix_vector_multiplier_if #(
    parameter int DATA_WIDTH = 8,
    parameter int MAT_ROW    = 2,
    parameter int MAT_COL    = 2
) ();
    logic                                            start;
    logic [MAT_ROW-1:0][MAT_COL-1:0][DATA_WIDTH-1:0] mat;
    logic [MAT_COL-1:0][DATA_WIDTH-1:0]              vec;
    logic [MAT_ROW-1:0][DATA_WIDTH-1:0]              res;
    logic                                            busy;
    logic                                            done;

    modport master (output start, mat, vec, input res, busy, done);
    modport slave  (input start, mat, vec, output res, busy, done);
endinterface

// File: rtl/matrix_vector_multiplier.sv
// Sequential unsigned matrix-vector multiplier, one multiply-accumulate per clock.
// Operands are captured when a start is accepted. Each result row is written
// as soon as its last column has been accumulated. Arithmetic wraps modulo
// 2^DATA_WIDTH.
// Ports:
//   clk   - clock, rising edge
//   rst_n - asynchronous active-low reset
//   bus   - start/mat/vec in, res/busy/done out (slave modport)
//
// state     | meaning
// ----------+-----------------------------------------------
// S_IDLE    | waiting for start, res holds the last result
// S_COMPUTE | one MAC per edge over row_q/col_q
module matrix_vector_multiplier #(
    parameter int DATA_WIDTH = 8,
    parameter int MAT_ROW    = 2,
    parameter int MAT_COL    = 2
) (
    input  logic                        clk,
    input  logic                        rst_n,
    matrix_vector_multiplier_if.slave   bus
);
    // A dimension of 1 still needs a 1-bit counter.
    localparam int ROW_W = (MAT_ROW > 1) ? $clog2(MAT_ROW) : 1;
    localparam int COL_W = (MAT_COL > 1) ? $clog2(MAT_COL) : 1;
    localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(MAT_ROW - 1);
    localparam logic [COL_W-1:0] COL_LAST = COL_W'(MAT_COL - 1);

    localparam logic [0:0] S_IDLE    = 1'b0;
    localparam logic [0:0] S_COMPUTE = 1'b1;

    logic [0:0]                                      state_q, state_d;
    logic [ROW_W-1:0]                                row_q, row_d;
    logic [COL_W-1:0]                                col_q, col_d;
    logic [DATA_WIDTH-1:0]                           acc_q, acc_d;
    logic [MAT_ROW-1:0][MAT_COL-1:0][DATA_WIDTH-1:0] mat_q, mat_d;
    logic [MAT_COL-1:0][DATA_WIDTH-1:0]              vec_q, vec_d;
    logic [MAT_ROW-1:0][DATA_WIDTH-1:0]              res_q, res_d;
    logic                                            done_q, done_d;

    logic [DATA_WIDTH-1:0] prod;
    logic [DATA_WIDTH-1:0] sum;

    // Both are sized to DATA_WIDTH, so the wrap-around is implicit.
    assign prod = mat_q[row_q][col_q] * vec_q[col_q];
    assign sum  = acc_q + prod;

    always_comb begin
        state_d = state_q;
        row_d   = row_q;
        col_d   = col_q;
        acc_d   = acc_q;
        mat_d   = mat_q;
        vec_d   = vec_q;
        res_d   = res_q;
        done_d  = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    mat_d   = bus.mat;
                    vec_d   = bus.vec;
                    acc_d   = '0;
                    row_d   = '0;
                    col_d   = '0;
                    state_d = S_COMPUTE;
                end
            end
            S_COMPUTE: begin
                if (col_q == COL_LAST) begin
                    res_d[row_q] = sum;
                    acc_d        = '0;
                    col_d        = '0;
                    if (row_q == ROW_LAST) begin
                        row_d   = '0;
                        done_d  = 1'b1;
                        state_d = S_IDLE;
                    end else begin
                        row_d = row_q + ROW_W'(1);
                    end
                end else begin
                    acc_d = sum;
                    col_d = col_q + COL_W'(1);
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            row_q   <= '0;
            col_q   <= '0;
            acc_q   <= '0;
            mat_q   <= '0;
            vec_q   <= '0;
            res_q   <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            row_q   <= row_d;
            col_q   <= col_d;
            acc_q   <= acc_d;
            mat_q   <= mat_d;
            vec_q   <= vec_d;
            res_q   <= res_d;
            done_q  <= done_d;
        end
    end

    assign bus.res  = res_q;
    assign bus.busy = (state_q == S_COMPUTE);
    assign bus.done = done_q;

endmodule

// File: tb/tb_matrix_vector_multiplier.sv
module tb_matrix_vector_multiplier;
    localparam int DW = 8;
    localparam int R  = 2;
    localparam int C  = 2;
    localparam int N  = R * C;

    typedef logic [R-1:0][C-1:0][DW-1:0] mat_t;
    typedef logic [C-1:0][DW-1:0]        vec_t;
    typedef logic [R-1:0][DW-1:0]        res_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    always #5 clk = ~clk;

    matrix_vector_multiplier_if #(.DATA_WIDTH(DW), .MAT_ROW(R), .MAT_COL(C)) bus ();

    matrix_vector_multiplier #(.DATA_WIDTH(DW), .MAT_ROW(R), .MAT_COL(C)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
        n_checks++;
        if (obs !== exp_v) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp_v);
        end
    endtask

    // Plain dot products, reduced modulo 2^DW at the end.
    function automatic res_t model(input mat_t m, input vec_t v);
        res_t r;
        for (int i = 0; i < R; i++) begin
            int s = 0;
            for (int j = 0; j < C; j++) s += int'(m[i][j]) * int'(v[j]);
            r[i] = DW'(s);
        end
        return r;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic rand_ops(output mat_t m, output vec_t v);
        for (int i = 0; i < R; i++)
            for (int j = 0; j < C; j++) m[i][j] = DW'($urandom);
        for (int j = 0; j < C; j++) v[j] = DW'($urandom);
    endtask

    task automatic run_job(input mat_t m, input vec_t v, input bit clobber, input string tag);
        res_t exp_r = model(m, v);
        int   lat   = 0;
        bus.mat   = m;
        bus.vec   = v;
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        check({tag, "_busy_start"}, bus.busy, 1);
        if (clobber) begin
            bus.mat = '0;
            bus.vec = '0;
        end
        while (!bus.done && lat < 20) begin
            tick();
            lat++;
        end
        check({tag, "_latency"}, lat, N);
        check({tag, "_res"}, bus.res, exp_r);
        check({tag, "_busy_done"}, bus.busy, 0);
        tick();
        check({tag, "_done_width"}, bus.done, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        mat_t mdir, mr;
        vec_t vdir, vr;
        res_t exp_h;
        int   last, cnt, waited;
        bit   prev;

        bus.start = 1'b0;
        bus.mat   = '0;
        bus.vec   = '0;

        #2;
        check("rst_res", bus.res, 0);
        check("rst_busy", bus.busy, 0);
        check("rst_done", bus.done, 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (6) begin
            tick();
            check("rst_no_done", bus.done, 0);
        end

        mdir = '0;
        mdir[1][1] = 8'd1;
        mdir[1][0] = 8'd2;
        mdir[0][1] = 8'd3;
        mdir[0][0] = 8'd4;
        vdir = '0;
        vdir[1] = 8'd1;
        vdir[0] = 8'd2;
        run_job(mdir, vdir, 1'b0, "dir");
        check("dir_const", bus.res, 16'h050B);

        run_job('1, '1, 1'b0, "ovf");
        check("ovf_const", bus.res, 16'h0202);

        run_job(mdir, vdir, 1'b1, "cap");
        check("cap_const", bus.res, 16'h050B);

        for (int k = 0; k < 20; k++) begin
            rand_ops(mr, vr);
            run_job(mr, vr, k[0], "rnd");
            repeat ($urandom_range(0, 3)) tick();
        end

        // Start held high: accepted on edges 1, 6, 11, 16; done after 5, 10, 15.
        rand_ops(mr, vr);
        exp_h     = model(mr, vr);
        bus.mat   = mr;
        bus.vec   = vr;
        bus.start = 1'b1;
        last = -1;
        cnt  = 0;
        prev = 1'b0;
        for (int c = 1; c <= 16; c++) begin
            tick();
            if (prev) check("hold_pulse_width", bus.done, 0);
            if (bus.done) begin
                cnt++;
                check("hold_res", bus.res, exp_h);
                if (last >= 0) check("hold_gap", c - last, N + 1);
                else check("hold_first", c, N + 1);
                last = c;
            end
            prev = bus.done;
        end
        check("hold_count", cnt, 3);
        bus.start = 1'b0;
        waited = 0;
        while (!bus.done && waited < 20) begin
            tick();
            waited++;
        end
        check("hold_tail_done", bus.done, 1);
        tick();

        // Abort a running job with an asynchronous reset.
        rand_ops(mr, vr);
        bus.mat   = mr;
        bus.vec   = vr;
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        tick();
        tick();
        #2;
        rst_n = 1'b0;
        #1;
        check("abort_res", bus.res, 0);
        check("abort_busy", bus.busy, 0);
        check("abort_done", bus.done, 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (6) begin
            tick();
            check("abort_no_done", bus.done, 0);
        end
        run_job(mdir, vdir, 1'b0, "post");
        check("post_const", bus.res, 16'h050B);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
